// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the bit-serial link
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  function automatic int frame_len(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// parity_acc: running XOR accumulator with clear/load/update controls
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic upd,
  input  logic din,
  output logic acc
);

  logic acc_q, acc_d;

  // load starts a new run and wins over clear so a restart in the final slot is kept
  always_comb acc_d = load ? din : clr ? 1'b0 : upd ? acc_q ^ din : acc_q;

  // accumulator register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= acc_d;

  assign acc = acc_q;

endmodule

// File: rtl/serial_sum_rx.sv
// serial_sum_rx: LSB-first serial word receiver with parity check and one-entry output buffer
module serial_sum_rx
  import serial_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sval,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             perr,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;
  logic             acc, start, take, done, accept, mismatch;

  // sof always (re)starts a frame; otherwise only DATA/PAR consume bits
  assign start    = sval & sof;
  assign take     = sval & ~sof & (state_q == DATA);
  assign done     = sval & ~sof & (state_q == PAR);
  assign accept   = ~dvalid_q | dready;
  assign mismatch = (acc ^ sin) != ODD_PAR;

  parity_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (done),
    .load  (start),
    .upd   (take),
    .din   (sin),
    .acc   (acc)
  );

  // frame FSM, bit counter and shift register; cnt saturates at the last data bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (start) begin
      state_d = DATA;
      cnt_d   = CW'(1);
      shreg_d = {{(WIDTH-1){1'b0}}, sin};
    end else if (take) begin
      shreg_d[cnt_q] = sin;
      cnt_d          = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
      state_d        = (cnt_q == LAST) ? PAR : DATA;
    end else if (done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // one-entry output buffer: a completed frame loads only if the slot is free or draining
  always_comb begin
    dout_d   = (done & accept) ? shreg_q  : dout_q;
    perr_d   = (done & accept) ? mismatch : perr_q;
    dvalid_d = done | (dvalid_q & ~dready);
    ovf_d    = done & ~accept;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ovf_q    <= ovf_d;
    end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign perr   = perr_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_serial_sum_rx.sv
// tb_serial_sum_rx: directed and randomized checks against a frame-level reference model
module tb_serial_sum_rx;
  import serial_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0, sval = 1'b0, sof = 1'b0, dready = 1'b0;
  logic [W-1:0] dout, dout_o;
  logic         dvalid, perr, ovf, busy;
  logic         dvalid_o, perr_o, ovf_o, busy_o;

  int checks = 0;
  int errors = 0;

  bit           mq[$];
  logic [W-1:0] m_dout;
  logic         m_valid, m_perr, m_perr_o, m_ovf;
  int           n_ovf, n_valid;

  always #5 clk = ~clk;

  serial_sum_rx #(.WIDTH(W), .ODD_PAR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sval(sval), .sof(sof),
    .dout(dout), .dvalid(dvalid), .dready(dready), .perr(perr), .ovf(ovf), .busy(busy)
  );

  serial_sum_rx #(.WIDTH(W), .ODD_PAR(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sval(sval), .sof(sof),
    .dout(dout_o), .dvalid(dvalid_o), .dready(dready), .perr(perr_o), .ovf(ovf_o), .busy(busy_o)
  );

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_valid = 0; m_perr = 0; m_perr_o = 0; m_ovf = 0;
  endtask

  // drive one cycle, advance the reference model, sample #1 after the edge
  task automatic drive(input logic i_sin, input logic i_sval, input logic i_sof, input logic i_rdy);
    logic [W-1:0] word;
    logic par, fin;
    @(negedge clk);
    sin = i_sin; sval = i_sval; sof = i_sof; dready = i_rdy;
    @(posedge clk);
    fin = 0; word = '0; par = 0;
    if (i_sval && i_sof) begin mq.delete(); mq.push_back(i_sin); end
    else if (i_sval && mq.size() > 0) mq.push_back(i_sin);
    if (mq.size() == frame_len(W)) begin
      fin = 1;
      for (int i = 0; i < W; i++) word[i] = mq[i];
      foreach (mq[i]) par ^= mq[i];
      mq.delete();
    end
    m_ovf = 0;
    if (fin && (!m_valid || i_rdy)) begin
      m_dout = word; m_valid = 1; m_perr = par; m_perr_o = ~par;
    end else if (fin) m_ovf = 1;
    else if (m_valid && i_rdy) m_valid = 0;
    #1;
    n_ovf += int'(ovf);
    n_valid += int'(dvalid);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic p, input logic rdy);
    for (int i = 0; i < W; i++) drive(w[i], 1'b1, i == 0, rdy);
    drive(p, 1'b1, 1'b0, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #3;
    checks++; if (dout !== 8'h00)  begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b want 0", dvalid); end
    checks++; if (perr !== 1'b0)   begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
    checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [W-1:0] w = 8'hA5;
    for (int i = 0; i < W; i++) drive(w[i], 1'b1, i == 0, 1'b1);
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", dvalid); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", dvalid); end
    checks++; if (dout !== 8'hA5)  begin errors++; $display("FAIL basic_dout got %h want a5", dout); end
    checks++; if (perr !== 1'b0)   begin errors++; $display("FAIL basic_perr got %b want 0", perr); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL basic_idle got %b want 0", busy); end
    idle(1);
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %b want 0", dvalid); end
    checks++; if (dout !== 8'hA5)  begin errors++; $display("FAIL basic_dout_hold got %h want a5", dout); end
  endtask

  task automatic test_parity();
    send_frame(8'hA5, 1'b1, 1'b1);
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL par_dout got %h want a5", dout); end
    checks++; if (perr !== 1'b1)  begin errors++; $display("FAIL par_even_err got %b want 1", perr); end
    checks++; if (perr_o !== 1'b0) begin errors++; $display("FAIL par_odd_ok got %b want 0", perr_o); end
    send_frame(8'h07, 1'b1, 1'b1);
    checks++; if (perr !== 1'b0)  begin errors++; $display("FAIL par_even_ok got %b want 0", perr); end
    checks++; if (perr_o !== 1'b1) begin errors++; $display("FAIL par_odd_err got %b want 1", perr_o); end
    idle(1);
  endtask

  task automatic test_ovf();
    n_ovf = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    checks++; if (ovf !== 1'b1)    begin errors++; $display("FAIL ovf_pulse got %b want 1", ovf); end
    checks++; if (n_ovf != 1)      begin errors++; $display("FAIL ovf_count got %0d want 1", n_ovf); end
    checks++; if (dout !== 8'h3C)  begin errors++; $display("FAIL ovf_dout got %h want 3c", dout); end
    checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", dvalid); end
    idle(1);
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %b want 0", dvalid); end
    checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
  endtask

  task automatic test_stall();
    logic [W-1:0] w = 8'h81;
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0, b = 0;
    while (b <= W) begin
      if (pat[k % 4]) begin
        drive(b < W ? w[b] : 1'b0, 1'b1, b == 0, 1'b1);
        b++;
      end else drive(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'b1);
      k++;
    end
    checks++; if (dout !== 8'h81)  begin errors++; $display("FAIL stall_dout got %h want 81", dout); end
    checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", dvalid); end
    checks++; if (perr !== 1'b0)   begin errors++; $display("FAIL stall_perr got %b want 0", perr); end
    idle(1);
  endtask

  task automatic test_abort();
    n_ovf = 0; n_valid = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i == 0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(1);
    checks++; if (n_valid != 1)   begin errors++; $display("FAIL abort_outputs got %0d want 1", n_valid); end
    checks++; if (n_ovf != 0)     begin errors++; $display("FAIL abort_ovf got %0d want 0", n_ovf); end
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL abort_dout got %h want 5a", dout); end
  endtask

  task automatic test_back_to_back();
    n_ovf = 0;
    send_frame(8'h12, 1'b0, 1'b1);
    checks++; if (dout !== 8'h12) begin errors++; $display("FAIL b2b_first got %h want 12", dout); end
    send_frame(8'hE7, 1'b0, 1'b1);
    checks++; if (dout !== 8'hE7)  begin errors++; $display("FAIL b2b_second got %h want e7", dout); end
    checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", dvalid); end
    checks++; if (n_ovf != 0)      begin errors++; $display("FAIL b2b_ovf got %0d want 0", n_ovf); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    send_frame(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, i == 0, 1'b0);
    rst_n = 0;
    model_reset();
    #2;
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", dvalid); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1;
    send_frame(8'hFF, 1'b0, 1'b1);
    checks++; if (dout !== 8'hFF)  begin errors++; $display("FAIL rstmid_dout got %h want ff", dout); end
    checks++; if (perr !== 1'b0)   begin errors++; $display("FAIL rstmid_perr got %b want 0", perr); end
    checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL rstmid_valid2 got %b want 1", dvalid); end
    idle(1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(1)), $urandom_range(3) != 0, $urandom_range(14) == 0, $urandom_range(2) != 0);
      checks++; if (dvalid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, dvalid, m_valid); end
      checks++; if (dout !== m_dout)    begin errors++; $display("FAIL rnd_dout cyc %0d got %h want %h", c, dout, m_dout); end
      checks++; if (perr !== m_perr)    begin errors++; $display("FAIL rnd_perr cyc %0d got %b want %b", c, perr, m_perr); end
      checks++; if (perr_o !== m_perr_o) begin errors++; $display("FAIL rnd_perr_odd cyc %0d got %b want %b", c, perr_o, m_perr_o); end
      checks++; if (ovf !== m_ovf)      begin errors++; $display("FAIL rnd_ovf cyc %0d got %b want %b", c, ovf, m_ovf); end
      checks++; if (busy !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy, mq.size() > 0); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_ovf();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
